mmu_loader: RTL
===============

# mmu_loader

Sequencer that bulk-loads the MMU translation table from memory on a context switch. On `start` it saves the MMU fault register and fetches all 4*NMMU entry words (instruction/data × supervisor/user × page) from a memory table. It programs each entry through the MMU's two-write register port, then restores the saved fault register. It sits between the context-switch logic, the memory bus and the MMU `reg_write`/`reg_data` port, and stalls the core while busy.

## Interface
- RV, 16, machine word width
- PA, RV, physical address width
- NMMU, 8, pages per map (power of 2); L = $clog2(NMMU), U = RV-L

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to load a table; ignored while busy
- base  in  PA  byte address of table entry 0
- busy  out  1  load in progress; also used as core stall / MMU hold
- done  out  1  one-cycle completion pulse
- err  out  1  last load aborted on memory error; held until the next accepted start
- mem_req  out  1  memory read request
- mem_addr  out  PA  read byte address
- mem_ack  in  1  read data valid this cycle
- mem_err  in  1  bus error, qualified by mem_ack
- mem_rdata  in  RV  read data
- mmu_reg_write  out  1  MMU register write strobe
- mmu_reg_data  out  RV  MMU register write data
- mmu_reg_read  in  RV  MMU fault register readback
- mmu_fault  in  1  MMU fault capture this cycle (pre-empts a register write)

## Operation
- Table layout: entry i (0..4*NMMU-1) is at base + i*(RV/8).
  - i[L+1] = ins, i[L] = sup, i[L-1:0] = page.
  - Entry word: bits [RV-1:U] = physical page, bit 2 = writeable, bit 1 = valid. Bit 0 is ignored.
- States: IDLE, SAVE, FETCH, WSEL, WENT, RESTORE, DONE.
- IDLE: on start, latch base, clear err, set i=0, go to SAVE.
- SAVE: latch mmu_reg_read into the save register, then go to FETCH.
- FETCH:
  - mem_req=1, mem_addr = base + i*(RV/8).
  - On mem_ack with !mem_err: latch mem_rdata and go to WSEL.
  - On mem_ack with mem_err: set err and go to RESTORE.
- WSEL: selects the entry.
  - mmu_reg_write=1, data = {page, zeros, ins, sup, 1'b0, 1'b0}.
  - Go to WENT.
- WENT: writes the entry.
  - mmu_reg_write=1, data = {latched[RV-1:3], latched[2], latched[1], 1'b1}.
  - If i == 4*NMMU-1, go to RESTORE; else i++ and go to FETCH.
- RESTORE: mmu_reg_write=1 with data = saved value, bit 0 forced to 0. Then go to DONE.
- DONE: done=1, then go to IDLE.
- Fault collision: if mmu_fault=1 in a cycle where mmu_reg_write=1, the MMU drops that write.
  - WSEL: repeat WSEL.
  - WENT: return to WSEL, because the entry index was overwritten.
  - RESTORE: repeat RESTORE.
  - Counter i and latched data are unchanged.
- Entries written before an error remain loaded; no rollback.
- Reset at any time: state IDLE, i=0, err=0. All outputs drop in the next cycle. A partially loaded table is left as is.

## Timing
- Reset values: busy=0, done=0, err=0, mem_req=0, mem_addr=0, mmu_reg_write=0, mmu_reg_data=0.
- Outputs decode from registered state; mem_addr and mmu_reg_data are driven only while their strobe is high, otherwise 0.
- mem_req is held until mem_ack; mem_addr is stable while mem_req=1. mem_ack in the first FETCH cycle is accepted.
- start sampled in cycle T → busy=1 from T+1 (SAVE).
- Zero-wait memory: 3 cycles per entry. For NMMU=8:
  - Last WENT at T+97, RESTORE at T+98.
  - done=1 and busy=1 at T+99; busy=0 at T+100.
  - A new start is accepted at T+100.
- Each memory wait cycle adds one cycle; each fault collision adds 1 cycle (WSEL, RESTORE) or 2 cycles (WENT).
- start asserted while busy has no effect.

## Test plan
- Zero-wait load: base=0x0100, NMMU=8, entry i = {i[7:0]^8'h5A, 5'b0, 1'b1, 1'b1, 1'b0} → 64 MMU writes, alternating bit0 = 0/1, in the order above; done at T+99; MMU readback restored to its pre-load value 0xE00A.
- Wait states: mem_ack delayed 2 cycles on every read → done at T+163; mem_addr holds each value until ack; addresses step by 2 from 0x0100 to 0x013E.
- Bus error at i=5: mem_err with ack → no entry-5 writes; RESTORE follows immediately; err=1 after done; entries 0-4 programmed.
- Fault collisions: mmu_fault pulsed during the WENT of i=3, then during RESTORE → WSEL(3) and WENT(3) reissued, RESTORE reissued; total latency +3; final table and fault register correct.
- Reset mid-load: reset at T+40 → busy, mem_req and mmu_reg_write all 0 the next cycle; a subsequent start performs a full correct load.
- start spam: start held high for 120 cycles → exactly two loads; the second begins at T+100.

Source files
------------

// File: rtl/mmu_loader_if.sv
// Bus bundle between the table loader, the memory read port and the
// MMU register port. The loader takes the master side.
interface mmu_loader_if #(
    parameter int RV = 16,
    parameter int PA = RV
);
    // memory read channel
    logic          mem_req;
    logic [PA-1:0] mem_addr;
    logic          mem_ack;
    logic          mem_err;
    logic [RV-1:0] mem_rdata;

    // MMU register port
    logic          mmu_reg_write;
    logic [RV-1:0] mmu_reg_data;
    logic [RV-1:0] mmu_reg_read;
    logic          mmu_fault;

    modport master (
        output mem_req, mem_addr, mmu_reg_write, mmu_reg_data,
        input  mem_ack, mem_err, mem_rdata, mmu_reg_read, mmu_fault
    );

    modport slave (
        input  mem_req, mem_addr, mmu_reg_write, mmu_reg_data,
        output mem_ack, mem_err, mem_rdata, mmu_reg_read, mmu_fault
    );
endinterface

// File: rtl/mmu_loader.sv
// Context-switch sequencer: saves the MMU fault register, streams all
// 4*NMMU translation entries from memory into the MMU through its
// select/write register pair, then restores the fault register.
module mmu_loader #(
    parameter int RV   = 16,
    parameter int PA   = RV,
    parameter int NMMU = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [PA-1:0] base,
    output logic          busy,
    output logic          done,
    output logic          err,
    mmu_loader_if.master  bus
);
    localparam int L    = $clog2(NMMU);
    localparam int IW   = L + 2;             // entry index: {ins, sup, page}
    localparam int NENT = 4 * NMMU;
    localparam int BSH  = $clog2(RV / 8);    // byte offset shift per word
    localparam logic [IW-1:0] LAST = IW'(NENT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SAVE, S_FETCH, S_WSEL, S_WENT, S_RESTORE, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [PA-1:0] base_q, base_d;
    logic [RV-1:0] save_q, save_d;
    logic [RV-1:0] data_q, data_d;
    logic          err_q, err_d;

    logic [PA-1:0] idx_ext;
    assign idx_ext = {{(PA-IW){1'b0}}, idx_q};
    assign err     = err_q;

    // State register; reset abandons any load in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            save_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            save_q  <= save_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Next-state and output decode; a concurrent MMU fault drops our
    // write, so each write state waits for a fault-free cycle
    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        base_d            = base_q;
        save_d            = save_q;
        data_d            = data_q;
        err_d             = err_q;
        busy              = (state_q != S_IDLE);
        done              = 1'b0;
        bus.mem_req       = 1'b0;
        bus.mem_addr      = '0;
        bus.mmu_reg_write = 1'b0;
        bus.mmu_reg_data  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = S_SAVE;
                end
            end
            S_SAVE: begin
                save_d  = bus.mmu_reg_read;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = base_q + (idx_ext << BSH);
                if (bus.mem_ack) begin
                    if (bus.mem_err) begin
                        err_d   = 1'b1;
                        state_d = S_RESTORE;
                    end else begin
                        data_d  = bus.mem_rdata;
                        state_d = S_WSEL;
                    end
                end
            end
            S_WSEL: begin
                bus.mmu_reg_write = 1'b1;
                bus.mmu_reg_data  = {idx_q[L-1:0], {(RV-L-4){1'b0}},
                                     idx_q[L+1], idx_q[L], 2'b00};
                if (!bus.mmu_fault) begin
                    state_d = S_WENT;
                end
            end
            S_WENT: begin
                bus.mmu_reg_write = 1'b1;
                bus.mmu_reg_data  = data_q | RV'(1);
                if (bus.mmu_fault) begin
                    // the fault clobbered the MMU's selected index
                    state_d = S_WSEL;
                end else if (idx_q == LAST) begin
                    state_d = S_RESTORE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = S_FETCH;
                end
            end
            S_RESTORE: begin
                bus.mmu_reg_write = 1'b1;
                bus.mmu_reg_data  = save_q & ~RV'(1);
                if (!bus.mmu_fault) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
